// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//   Physical-register free list sitting at the consuming end of the ROB retire
//   interface. Up to WAYS retiring packets per cycle push their Told back onto
//   the list, and up to WAYS free registers per cycle are offered to rename as
//   Tnew. An architectural head pointer tracks the allocations that have
//   committed, so a squash returns every speculative allocation in one cycle.
//
// Ports
//   clock         system clock, rising edge
//   reset         asynchronous, active-high reset
//   dispatch_num  registers consumed by rename this cycle (0..3), clipped
//   retire_valid  per-way retire valid, packed from way 0
//   retire_Told   Told of each retiring ROB entry, way k at [k*PR +: PR]
//   squash        flush all speculative allocations at the end of this cycle
//   free_pr       next free registers, way i = entry at head+i
//   avail_num     min(WAYS, count): number of valid free_pr ways
//   empty         count == 0
// -----------------------------------------------------------------------------
module free_list #(
  parameter int PR       = 6,
  parameter int ARCH_NUM = 32,
  parameter int WAYS     = 3,
  parameter int FL_SIZE  = (1 << PR) - ARCH_NUM
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           dispatch_num,
  input  logic [WAYS-1:0]      retire_valid,
  input  logic [WAYS*PR-1:0]   retire_Told,
  input  logic                 squash,
  output logic [WAYS*PR-1:0]   free_pr,
  output logic [1:0]           avail_num,
  output logic                 empty
);

  localparam int IW = $clog2(FL_SIZE);
  // One extra wrap bit separates the full (count == FL_SIZE) and empty cases.
  localparam int PW = IW + 1;

  logic [PR-1:0] entries [FL_SIZE];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] arch_head;

  logic [PW-1:0] head_nxt;
  logic [PW-1:0] tail_nxt;
  logic [PW-1:0] arch_head_nxt;

  logic [PW-1:0] count;
  logic [PW-1:0] space;
  logic [1:0]    avail;
  logic [1:0]    alloc;
  logic [1:0]    ret_num;
  logic [1:0]    ret_eff;

  // ---------------------------------------------------------------------------
  // Occupancy and allocation view, from registered state only
  // ---------------------------------------------------------------------------
  assign count = tail - head;
  assign space = PW'(FL_SIZE) - count;

  always_comb begin
    avail = count[1:0];
    if (count >= PW'(WAYS)) begin
      avail = 2'(WAYS);
    end
  end

  assign avail_num = avail;
  assign empty     = (count == '0);

  for (genvar g = 0; g < WAYS; g++) begin : g_rd
    logic [IW-1:0] rd_idx;
    assign rd_idx                = head[IW-1:0] + IW'(g);
    assign free_pr[g*PR +: PR]   = entries[rd_idx];
  end

  // Over-requests are clipped to what is actually on offer.
  assign alloc = (dispatch_num < avail) ? dispatch_num : avail;

  // ---------------------------------------------------------------------------
  // Retire side
  // ---------------------------------------------------------------------------
  always_comb begin
    ret_num = '0;
    for (int k = 0; k < WAYS; k++) begin
      ret_num = ret_num + 2'(retire_valid[k]);
    end
  end

  // A protocol-violating overflow is clipped to the free space so the ring
  // never overwrites live entries and the pointer relationship stays intact.
  assign ret_eff = (PW'(ret_num) > space) ? space[1:0] : ret_num;

  assign tail_nxt      = tail + PW'(ret_eff);
  assign arch_head_nxt = arch_head + PW'(ret_eff);

  // On squash the speculative head snaps back to the committed position,
  // including this cycle's retires; dispatch is ignored that cycle.
  assign head_nxt = squash ? arch_head_nxt : head + PW'(alloc);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head      <= '0;
      arch_head <= '0;
      tail      <= PW'(FL_SIZE);
    end else begin
      head      <= head_nxt;
      arch_head <= arch_head_nxt;
      tail      <= tail_nxt;
    end
  end

  // Reads above only see the old contents, so writes at tail never race a
  // same-cycle allocation; freed registers appear on free_pr one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        entries[i] <= PR'(ARCH_NUM + i);
      end
    end else begin
      for (int k = 0; k < WAYS; k++) begin
        if (2'(k) < ret_eff) begin
          entries[tail[IW-1:0] + IW'(k)] <= retire_Told[k*PR +: PR];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert ((PW+1)'(count) + (PW+1)'(ret_num) <= (PW+1)'(FL_SIZE))
        else $error("free_list: retire overflow, count=%0d retires=%0d", count, ret_num);
      assert ((retire_valid & (retire_valid + WAYS'(1))) == '0)
        else $error("free_list: retire_valid not packed from way 0: %b", retire_valid);
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

  localparam int PR   = 6;
  localparam int WAYS = 3;

  logic                clock = 1'b0;
  logic                reset;
  logic [1:0]          dispatch_num;
  logic [WAYS-1:0]     retire_valid;
  logic [WAYS*PR-1:0]  retire_Told;
  logic                squash;
  logic [WAYS*PR-1:0]  free_pr;
  logic [1:0]          avail_num;
  logic                empty;

  int checks   = 0;
  int failures = 0;

  free_list dut (
    .clock        (clock),
    .reset        (reset),
    .dispatch_num (dispatch_num),
    .retire_valid (retire_valid),
    .retire_Told  (retire_Told),
    .squash       (squash),
    .free_pr      (free_pr),
    .avail_num    (avail_num),
    .empty        (empty)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  function automatic logic [PR-1:0] fp(input int i);
    return free_pr[i*PR +: PR];
  endfunction

  // Ways at index >= avail are don't-care, so only the valid ones are checked.
  task automatic chk_out(input string tag, input int p0, input int p1, input int p2,
                         input int av, input int em);
    chk({tag, "_avail"}, 32'(avail_num), 32'(av));
    chk({tag, "_empty"}, 32'(empty), 32'(em));
    if (av > 0) chk({tag, "_pr0"}, 32'(fp(0)), 32'(p0));
    if (av > 1) chk({tag, "_pr1"}, 32'(fp(1)), 32'(p1));
    if (av > 2) chk({tag, "_pr2"}, 32'(fp(2)), 32'(p2));
  endtask

  // arch_head <= head <= tail in wrap arithmetic, and count never exceeds 32.
  task automatic chk_inv();
    logic [5:0] dh;
    logic [5:0] dt;
    logic       ok;
    dh = dut.head - dut.arch_head;
    dt = dut.tail - dut.arch_head;
    ok = (dh <= dt) && ((dt - dh) <= 6'd32);
    chk("invariant", 32'(ok), 32'd1);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    chk_inv();
  endtask

  task automatic idle_inputs();
    dispatch_num = 2'd0;
    retire_valid = '0;
    retire_Told  = '0;
    squash       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    #12;
    reset = 1'b0;
    #1;

    // 1: reset state, stable while idle
    chk_out("t1_reset", 32, 33, 34, 3, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("t1_idle", 32, 33, 34, 3, 0);
    end

    // 2: drain with full-width dispatch, then an over-request is clipped
    dispatch_num = 2'd3;
    repeat (10) tick();
    chk_out("t2_ten", 62, 63, 0, 2, 0);
    chk("t2_head30", 32'(dut.head), 32'd30);
    tick();
    dispatch_num = 2'd0;
    chk_out("t2_clip", 0, 0, 0, 0, 1);
    chk("t2_head32", 32'(dut.head), 32'd32);

    // 3: retire three while empty; no same-cycle bypass, tail wraps to index 0
    retire_valid = 3'b111;
    retire_Told  = {6'd2, 6'd6, 6'd5};
    #1;
    chk("t3_nobypass_empty", 32'(empty), 32'd1);
    chk("t3_nobypass_avail", 32'(avail_num), 32'd0);
    tick();
    idle_inputs();
    chk_out("t3_refill", 5, 6, 2, 3, 0);
    chk("t3_tail", 32'(dut.tail), 32'd35);

    // 4: simultaneous allocate 2 and retire 1
    dispatch_num = 2'd2;
    retire_valid = 3'b001;
    retire_Told  = {6'd0, 6'd0, 6'd9};
    tick();
    idle_inputs();
    chk_out("t4_mixed", 2, 9, 0, 2, 0);
    chk("t4_head", 32'(dut.head), 32'd34);
    chk("t4_arch_head", 32'(dut.arch_head), 32'd4);

    // 5: fresh reset, allocate 6, squash with two retires
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk_out("t5_reset", 32, 33, 34, 3, 0);
    dispatch_num = 2'd3;
    tick();
    tick();
    dispatch_num = 2'd0;
    chk_out("t5_alloc6", 38, 39, 40, 3, 0);
    chk("t5_head6", 32'(dut.head), 32'd6);
    squash       = 1'b1;
    dispatch_num = 2'd3;
    retire_valid = 3'b011;
    retire_Told  = {6'd0, 6'd8, 6'd7};
    tick();
    idle_inputs();
    chk("t5_head", 32'(dut.head), 32'd2);
    chk("t5_tail", 32'(dut.tail), 32'd34);
    chk("t5_arch_head", 32'(dut.arch_head), 32'd2);
    chk("t5_count", 32'(6'(dut.tail - dut.head)), 32'd32);
    chk_out("t5_squash", 34, 35, 36, 3, 0);
    chk("t5_entry0", 32'(dut.entries[0]), 32'd7);
    chk("t5_entry1", 32'(dut.entries[1]), 32'd8);
    chk("t5_entry2", 32'(dut.entries[2]), 32'd34);

    // 6: reset between edges; the activity presented that cycle is lost
    dispatch_num = 2'd3;
    retire_valid = 3'b111;
    retire_Told  = {6'd3, 6'd2, 6'd1};
    #3;
    reset = 1'b1;
    #1;
    chk_out("t6_async", 32, 33, 34, 3, 0);
    chk("t6_head_async", 32'(dut.head), 32'd0);
    chk("t6_tail_async", 32'(dut.tail), 32'd32);
    tick();
    chk("t6_entry0_held", 32'(dut.entries[0]), 32'd32);
    chk("t6_head_held", 32'(dut.head), 32'd0);
    idle_inputs();
    reset = 1'b0;
    #1;
    chk_out("t6_release", 32, 33, 34, 3, 0);
    tick();
    chk_out("t6_stable", 32, 33, 34, 3, 0);

    // 7: squash with nothing speculative, then a single allocation
    squash       = 1'b1;
    dispatch_num = 2'd2;
    tick();
    idle_inputs();
    chk_out("t7_squash_idle", 32, 33, 34, 3, 0);
    chk("t7_head", 32'(dut.head), 32'd0);
    dispatch_num = 2'd1;
    tick();
    idle_inputs();
    chk_out("t7_alloc1", 33, 34, 35, 3, 0);
    chk("t7_arch_head", 32'(dut.arch_head), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
